// File: rtl/reg_file.sv
// Architectural register file: one synchronous write port, two combinational read ports.
// Each row is a bank of enable flops driven by a one-hot write decoder; the ZERO_REG row always reads 0.
module reg_file #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 31
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     reg_write,
   input  logic [$clog2(DEPTH)-1:0] write_register,
   input  logic [WIDTH-1:0]         write_data,
   input  logic [$clog2(DEPTH)-1:0] read_register1,
   input  logic [$clog2(DEPTH)-1:0] read_register2,
   output logic [WIDTH-1:0]         read_data1,
   output logic [WIDTH-1:0]         read_data2
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] row_en;
   logic [WIDTH-1:0] row_q [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_row
         logic [WIDTH-1:0] data_reg;
         logic [WIDTH-1:0] data_next;

         // The zero row keeps its flops but its enable is tied off, so it never leaves reset.
         if (gi == ZERO_REG) begin : g_zero
            assign row_en[gi] = 1'b0;
         end else begin : g_live
            assign row_en[gi] = reg_write && (write_register == AW'(gi));
         end

         assign data_next = row_en[gi] ? write_data : data_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               data_reg <= '0;
            end else begin
               data_reg <= data_next;
            end
         end

         assign row_q[gi] = data_reg;
      end
   endgenerate

   // No write bypass: a same-cycle read sees the pre-edge contents.
   assign read_data1 = (read_register1 == AW'(ZERO_REG)) ? '0 : row_q[read_register1];
   assign read_data2 = (read_register2 == AW'(ZERO_REG)) ? '0 : row_q[read_register2];

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 64-bit architectural register file.
- Consumes per-bit enable flip-flop storage: each register is a row of enable flops, and the row enable comes from a 5:32 write decoder gated by reg_write.
- Sits between the datapath write-back stage and the operand-read stage.
- One synchronous write port, two combinational read ports; register 31 is hardwired to zero (XZR).

Parameters:
- WIDTH, 64, data width of each register.
- DEPTH, 32, number of registers; index width is log2(DEPTH) = 5.
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all registers immediately.
- reg_write  input  1  write enable for the write port.
- write_register  input  5  destination register index.
- write_data  input  WIDTH  data to write.
- read_register1  input  5  index for read port 1.
- read_register2  input  5  index for read port 2.
- read_data1  output  WIDTH  contents of register read_register1.
- read_data2  output  WIDTH  contents of register read_register2.

Behaviour:
- Reset:
  - reset=1 asynchronously forces every register to 0, independent of clk.
  - Both read outputs are 0 while reset is held.
  - Deassertion takes effect at the next rising clk.
  - Reset asserted in the same cycle as a write: reset wins and the write is lost.
- Write:
  - On rising clk with reset=0 and reg_write=1, register[write_register] <= write_data.
  - Write latency is 1 cycle: the new value is visible on reads after the edge.
  - reg_write=0: no register changes; every storage flop recirculates its value (enable=0 path).
- Decode:
  - Exactly one row enable is active when reg_write=1 and write_register != ZERO_REG.
  - No row enable is active otherwise.
  - The ZERO_REG row has no storage, or its storage is never enabled.
- Read:
  - Purely combinational, 0-cycle latency: read_dataN = register[read_registerN].
  - read_registerN == ZERO_REG returns 0 regardless of prior writes.
  - Both ports may address the same register and return identical data.
- Read-during-write:
  - A same-cycle read of the register being written returns the OLD value until the clock edge.
  - There is no internal bypass; forwarding is the datapath's responsibility.
- No X propagation: after reset, every read returns a defined value.

Test Plan:
- Assert reset mid-simulation with no clk edge -> read_data1 and read_data2 go to 0 immediately for every index 0..31.
- Write reg k with value 64'h0000_0000_0000_1000 + k for k=0..30, then read all pairs (k, 30-k) -> each port returns its written value; a read of reg 31 returns 0.
- reg_write=1, write_register=31, write_data=64'hFFFF_FFFF_FFFF_FFFF -> reading reg 31 on both ports returns 0; regs 0..30 are unchanged.
- Hold reg_write=0 and toggle write_register/write_data over 10 cycles -> all registers keep their prior contents.
- Write reg 5 = 64'hA5A5_A5A5_A5A5_A5A5 while read_register1=5 in the same cycle:
  - before the edge, read_data1 shows the old value 64'h0000_0000_0000_1005;
  - after the edge, read_data1 shows 64'hA5A5....
- Write reg 7 with reset asserted in the same cycle -> reg 7 reads 0 after reset deasserts.
